corevx_ptw: RTL and testbench
=============================

COREVX_PTW -- requirements
Module: corevx_ptw

Interface
REQ-001 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-002 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port satp_mode  input  1  0 = bare, 1 = Sv32.
REQ-004 SHALL have port satp_ppn  input  22  root page-table PPN.
REQ-005 SHALL have port resolve_request  input  1  walk request; sampled only in IDLE.
REQ-006 SHALL have port resolve_virtual_address  input  20  VPN of the request.
REQ-007 SHALL have ports resolve_ack (output, 1) and resolve_done (output, 1), each a one-cycle pulse.
REQ-008 SHALL have ports resolve_pagefault (output, 1) and resolve_accessfault (output, 1), valid with resolve_done.
REQ-009 SHALL have ports resolve_physical_address (output, 22) and resolve_access_bits (output, 8, PTE[7:0]), valid with resolve_done.
REQ-010 SHALL have memory ports mem_read (output, 1), mem_address (output, 34), mem_waitrequest (input, 1), mem_readdatavalid (input, 1), mem_readdata (input, 32) and mem_response (input, 2, 0 = OKAY).
REQ-011 SHALL have TLB fill ports tlb_write (output, 1), tlb_virtual_address_w (output, 20), tlb_phys_w (output, 22) and tlb_accesstag_w (output, 8).

Function
REQ-012 SHALL implement the states IDLE, ISSUE, WAIT and DONE; a 1-bit level register starts at 1.
REQ-013 In IDLE with resolve_request=1, SHALL pulse resolve_ack, latch the VA and satp_ppn into the table pointer, set level=1, and go to ISSUE (Sv32) or DONE (bare).
REQ-014 Bare mode: SHALL take DONE the next cycle with physical_address={2'b00,VA}, access_bits=8'hFF, no faults and no tlb_write.
REQ-015 ISSUE: SHALL drive mem_read=1 with mem_address={ptr,VPN[level],2'b00}, holding both stable while mem_waitrequest=1, and go to WAIT in the cycle mem_waitrequest=0.
REQ-016 WAIT: SHALL ignore mem_readdata until mem_readdatavalid=1, and SHALL drive mem_read=0.
REQ-017 On a response with mem_response!=0, SHALL go to DONE with accessfault=1 and pagefault=0.
REQ-018 A PTE with V=0, or with R=0 and W=1, SHALL go to DONE with pagefault=1.
REQ-019 A PTE with R=1 or X=1 is a leaf: at level 1 with PTE[19:10]!=0, SHALL go to DONE with pagefault=1 (misaligned megapage).
REQ-020 A valid leaf SHALL go to DONE with physical_address=PTE[31:10] (level 0) or {PTE[31:20],VPN[9:0]} (level 1) and access_bits=PTE[7:0].
REQ-021 A non-leaf PTE at level 1 SHALL set ptr=PTE[31:10] and level=0, and return to ISSUE.
REQ-022 A non-leaf PTE at level 0 SHALL go to DONE with pagefault=1.
REQ-023 DONE: SHALL assert resolve_done for exactly one cycle, then return to IDLE.
REQ-024 In the DONE cycle of a successful Sv32 walk, tlb_write SHALL be 1 with {VA, physical_address, access_bits} on the tlb_*_w ports.
REQ-025 tlb_write SHALL be 0 on any fault and in bare mode.
REQ-026 A resolve_request outside IDLE SHALL be ignored, with no ack.
REQ-027 All resolve_* and tlb_* outputs SHALL be registered.
REQ-028 Minimum Sv32 latency: ack at cycle 0, ISSUE at cycle 1, data at cycle 2, done at cycle 3 for one level; each extra level and each waitrequest or response-wait cycle adds one cycle.

Reset
REQ-029 With rst=1, the next state SHALL be IDLE, and mem_read, resolve_ack, resolve_done, both faults and tlb_write SHALL be 0.
REQ-030 Data outputs SHALL reset to 0.
REQ-031 Reset mid-walk SHALL abort the walk; a mem_readdatavalid arriving afterwards in IDLE SHALL be ignored.

Configuration
REQ-032 With COREVX_PTW_ABIT_CHECK_EN defined, a valid leaf with A=0 SHALL produce a pagefault and no tlb_write.
REQ-033 Without COREVX_PTW_ABIT_CHECK_EN, the A bit SHALL be ignored.

Structure
REQ-034 Package corevx_pkg SHALL hold the PTE bit indices (V,R,W,X,U,G,A,D), the state enum and the response code OKAY.
REQ-035 A combinational sub-module corevx_ptw_pte_check SHALL classify a PTE as invalid, leaf, misaligned or pointer.

Verification
REQ-036 Bare mode: satp_mode=0, VA=20'h2_0000 -> done at cycle 1, phys=22'h2_0000, no mem_read, no tlb_write.
REQ-037 Two-level walk: root ppn=22'h100, L1 PTE=32'h0000_8001, L0 PTE=32'h0400_00CF -> mem_address 34'h100_0800 then 34'h20_xxxx, done with phys=22'h1_0000, access=8'hCF, tlb_write=1.
REQ-038 Megapage: L1 PTE=32'h2000_00CF, VA=20'h2_0003 -> phys=22'h8_0003; L1 PTE=32'h2000_04CF -> pagefault, no tlb_write.
REQ-039 Faults: mem_response=2 -> accessfault; PTE=32'h0 -> pagefault; level-0 pointer PTE -> pagefault.
REQ-040 Stall and reset: waitrequest held for 3 cycles -> address stable and done delayed by 3 cycles; rst during WAIT -> IDLE, and a later readdatavalid produces no done.

Source files
------------

// File: rtl/corevx_pkg.sv
// Shared PTE field indices, walker state encoding and bus response codes.
package corevx_pkg;

    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } ptw_state_t;

endpackage

// File: rtl/corevx_ptw_pte_check.sv
// Combinational Sv32 PTE classifier: invalid, leaf, misaligned leaf or pointer.
module corevx_ptw_pte_check
    import corevx_pkg::*;
(
    input  logic [31:0] i_pte,
    input  logic        i_level,
    output logic        o_invalid,
    output logic        o_leaf,
    output logic        o_misaligned,
    output logic        o_pointer
);

    logic w_rx;
    logic w_unused;

    assign w_rx         = i_pte[PTE_R] | i_pte[PTE_X];
    assign o_invalid    = ~i_pte[PTE_V] | (~i_pte[PTE_R] & i_pte[PTE_W]);
    assign o_leaf       = ~o_invalid & w_rx;
    // A megapage leaf must have a zero low PPN field.
    assign o_misaligned = o_leaf & i_level & (|i_pte[19:10]);
    assign o_pointer    = ~o_invalid & ~w_rx;

    assign w_unused = &{1'b0, i_pte[31:20], i_pte[9:4]};

endmodule

// File: rtl/corevx_ptw.sv
// Sv32 hardware page-table walker with bare-mode bypass and TLB fill.
// Optional accessed-bit enforcement: define COREVX_PTW_ABIT_CHECK_EN.
module corevx_ptw
    import corevx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        satp_mode,
    input  logic [21:0] satp_ppn,
    input  logic        resolve_request,
    input  logic [19:0] resolve_virtual_address,
    output logic        resolve_ack,
    output logic        resolve_done,
    output logic        resolve_pagefault,
    output logic        resolve_accessfault,
    output logic [21:0] resolve_physical_address,
    output logic [7:0]  resolve_access_bits,
    output logic        mem_read,
    output logic [33:0] mem_address,
    input  logic        mem_waitrequest,
    input  logic        mem_readdatavalid,
    input  logic [31:0] mem_readdata,
    input  logic [1:0]  mem_response,
    output logic        tlb_write,
    output logic [19:0] tlb_virtual_address_w,
    output logic [21:0] tlb_phys_w,
    output logic [7:0]  tlb_accesstag_w
);

    ptw_state_t r_state;
    ptw_state_t w_next;

    logic        r_level;
    logic [19:0] r_va;
    logic [21:0] r_ptr;

    logic        r_pend_pf;
    logic        r_pend_af;
    logic        r_pend_ok;
    logic [21:0] r_pend_phys;
    logic [7:0]  r_pend_acc;

    logic        r_ack;
    logic        r_done;
    logic        r_pf;
    logic        r_af;
    logic [21:0] r_phys;
    logic [7:0]  r_acc;
    logic        r_tlbw;
    logic [19:0] r_tlb_va;
    logic [21:0] r_tlb_phys;
    logic [7:0]  r_tlb_acc;

    logic w_invalid;
    logic w_leaf;
    logic w_misaligned;
    logic w_pointer;
    logic w_rsp;
    logic w_resp_err;
    logic w_abit_fault;
    logic w_descend;

    corevx_ptw_pte_check u_check (
        .i_pte        (mem_readdata),
        .i_level      (r_level),
        .o_invalid    (w_invalid),
        .o_leaf       (w_leaf),
        .o_misaligned (w_misaligned),
        .o_pointer    (w_pointer)
    );

`ifdef COREVX_PTW_ABIT_CHECK_EN
    assign w_abit_fault = ~mem_readdata[PTE_A];
`else
    assign w_abit_fault = 1'b0;
`endif

    assign w_rsp      = (r_state == S_WAIT) & mem_readdatavalid;
    assign w_resp_err = (mem_response != RESP_OKAY);
    assign w_descend  = ~w_resp_err & w_pointer & r_level;

    assign mem_read    = (r_state == S_ISSUE) & ~rst;
    assign mem_address = {r_ptr, (r_level ? r_va[19:10] : r_va[9:0]), 2'b00};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (resolve_request)
                    w_next = satp_mode ? S_ISSUE : S_DONE;
            end
            S_ISSUE: begin
                if (!mem_waitrequest) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (mem_readdatavalid)
                    w_next = w_descend ? S_ISSUE : S_DONE;
            end
            S_DONE: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level     <= 1'b1;
            r_va        <= '0;
            r_ptr       <= '0;
            r_pend_pf   <= 1'b0;
            r_pend_af   <= 1'b0;
            r_pend_ok   <= 1'b0;
            r_pend_phys <= '0;
            r_pend_acc  <= '0;
            r_ack       <= 1'b0;
            r_done      <= 1'b0;
            r_pf        <= 1'b0;
            r_af        <= 1'b0;
            r_phys      <= '0;
            r_acc       <= '0;
            r_tlbw      <= 1'b0;
            r_tlb_va    <= '0;
            r_tlb_phys  <= '0;
            r_tlb_acc   <= '0;
        end else begin
            r_ack  <= 1'b0;
            r_done <= 1'b0;
            r_pf   <= 1'b0;
            r_af   <= 1'b0;
            r_tlbw <= 1'b0;
            if (r_state == S_IDLE && resolve_request) begin
                r_ack       <= 1'b1;
                r_va        <= resolve_virtual_address;
                r_ptr       <= satp_ppn;
                r_level     <= 1'b1;
                r_pend_pf   <= 1'b0;
                r_pend_af   <= 1'b0;
                r_pend_ok   <= 1'b0;
                r_pend_phys <= {2'b00, resolve_virtual_address};
                r_pend_acc  <= satp_mode ? 8'h00 : 8'hFF;
            end
            if (w_rsp) begin
                if (w_resp_err) begin
                    r_pend_af <= 1'b1;
                end else if (w_invalid) begin
                    r_pend_pf <= 1'b1;
                end else if (w_leaf) begin
                    if (w_misaligned || w_abit_fault) begin
                        r_pend_pf <= 1'b1;
                    end else begin
                        r_pend_ok   <= 1'b1;
                        r_pend_acc  <= mem_readdata[7:0];
                        r_pend_phys <= r_level ?
                            {mem_readdata[31:20], r_va[9:0]} :
                            mem_readdata[31:10];
                    end
                end else if (r_level) begin
                    r_ptr   <= mem_readdata[31:10];
                    r_level <= 1'b0;
                end else begin
                    r_pend_pf <= 1'b1;
                end
            end
            // Results publish on leaving DONE so done trails ack by a cycle.
            if (r_state == S_DONE) begin
                r_done     <= 1'b1;
                r_pf       <= r_pend_pf;
                r_af       <= r_pend_af;
                r_phys     <= r_pend_phys;
                r_acc      <= r_pend_acc;
                r_tlbw     <= r_pend_ok;
                r_tlb_va   <= r_va;
                r_tlb_phys <= r_pend_phys;
                r_tlb_acc  <= r_pend_acc;
            end
        end
    end

    assign resolve_ack              = r_ack;
    assign resolve_done             = r_done;
    assign resolve_pagefault        = r_pf;
    assign resolve_accessfault      = r_af;
    assign resolve_physical_address = r_phys;
    assign resolve_access_bits      = r_acc;
    assign tlb_write                = r_tlbw;
    assign tlb_virtual_address_w    = r_tlb_va;
    assign tlb_phys_w               = r_tlb_phys;
    assign tlb_accesstag_w          = r_tlb_acc;

endmodule

// File: tb/tb_corevx_ptw.sv
// Directed bench for corevx_ptw with a small address-indexed PTE memory.
module tb_corevx_ptw;

    logic        clk = 1'b0;
    logic        rst;
    logic        satp_mode;
    logic [21:0] satp_ppn;
    logic        resolve_request;
    logic [19:0] resolve_virtual_address;
    logic        resolve_ack;
    logic        resolve_done;
    logic        resolve_pagefault;
    logic        resolve_accessfault;
    logic [21:0] resolve_physical_address;
    logic [7:0]  resolve_access_bits;
    logic        mem_read;
    logic [33:0] mem_address;
    logic        mem_waitrequest = 1'b0;
    logic        mem_readdatavalid = 1'b0;
    logic [31:0] mem_readdata = 32'hDEAD_BEEF;
    logic [1:0]  mem_response = 2'b00;
    logic        tlb_write;
    logic [19:0] tlb_virtual_address_w;
    logic [21:0] tlb_phys_w;
    logic [7:0]  tlb_accesstag_w;

    corevx_ptw dut (
        .clk                      (clk),
        .rst                      (rst),
        .satp_mode                (satp_mode),
        .satp_ppn                 (satp_ppn),
        .resolve_request          (resolve_request),
        .resolve_virtual_address  (resolve_virtual_address),
        .resolve_ack              (resolve_ack),
        .resolve_done             (resolve_done),
        .resolve_pagefault        (resolve_pagefault),
        .resolve_accessfault      (resolve_accessfault),
        .resolve_physical_address (resolve_physical_address),
        .resolve_access_bits      (resolve_access_bits),
        .mem_read                 (mem_read),
        .mem_address              (mem_address),
        .mem_waitrequest          (mem_waitrequest),
        .mem_readdatavalid        (mem_readdatavalid),
        .mem_readdata             (mem_readdata),
        .mem_response             (mem_response),
        .tlb_write                (tlb_write),
        .tlb_virtual_address_w    (tlb_virtual_address_w),
        .tlb_phys_w               (tlb_phys_w),
        .tlb_accesstag_w          (tlb_accesstag_w)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // memory model configuration (written by the test process only)
    logic [33:0] e_addr [0:3];
    logic [31:0] e_pte  [0:3];
    logic [1:0]  e_resp [0:3];
    int          m_wait = 0;
    int          m_lat  = 0;

    // memory model state (written by the responder only)
    int          wcnt = 0;
    int          pend_cnt = 0;
    logic [33:0] pend_addr = '0;
    logic [33:0] first_addr = '0;
    int          n_reads = 0;
    int          unstable_cnt = 0;
    logic [33:0] addr_log [0:3];

    always @(negedge clk) begin
        mem_readdatavalid = 1'b0;
        mem_readdata      = 32'hDEAD_BEEF;
        mem_response      = 2'b11;
        if (pend_cnt > 0) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = 32'h0;
                mem_response      = 2'b00;
                for (int k = 0; k < 4; k++) begin
                    if (e_addr[k] == pend_addr) begin
                        mem_readdata = e_pte[k];
                        mem_response = e_resp[k];
                    end
                end
            end
        end
        if (mem_read) begin
            if (wcnt == 0) first_addr = mem_address;
            else if (mem_address !== first_addr) unstable_cnt++;
            if (wcnt < m_wait) begin
                mem_waitrequest = 1'b1;
                wcnt++;
            end else begin
                mem_waitrequest = 1'b0;
                wcnt = 0;
                addr_log[n_reads % 4] = mem_address;
                n_reads++;
                pend_cnt  = m_lat + 1;
                pend_addr = mem_address;
            end
        end else begin
            mem_waitrequest = 1'b0;
            wcnt = 0;
        end
    end

    // captured results of the last walk
    logic        c_ack, c_got, c_after;
    int          c_lat;
    logic        c_pf, c_af, c_tlbw;
    logic [21:0] c_phys, c_tlbphys;
    logic [7:0]  c_acc, c_tlbacc;
    logic [19:0] c_tlbva;

    task automatic set_tbl(input int i, input logic [33:0] a,
                           input logic [31:0] p, input logic [1:0] r);
        e_addr[i] = a;
        e_pte[i]  = p;
        e_resp[i] = r;
    endtask

    task automatic clr_tbl();
        for (int i = 0; i < 4; i++) set_tbl(i, 34'h3_FFFF_FFFF, 32'h0, 2'b00);
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic run_walk(input logic mode, input logic [19:0] va,
                            input logic [21:0] ppn);
        satp_mode = mode;
        satp_ppn  = ppn;
        resolve_virtual_address = va;
        resolve_request = 1'b1;
        @(negedge clk);
        resolve_request = 1'b0;
        c_ack = resolve_ack;
        c_got = 1'b0;
        c_lat = 0;
        for (int i = 1; i <= 40 && !c_got; i++) begin
            @(negedge clk);
            if (resolve_done) begin
                c_got     = 1'b1;
                c_lat     = i;
                c_pf      = resolve_pagefault;
                c_af      = resolve_accessfault;
                c_phys    = resolve_physical_address;
                c_acc     = resolve_access_bits;
                c_tlbw    = tlb_write;
                c_tlbva   = tlb_virtual_address_w;
                c_tlbphys = tlb_phys_w;
                c_tlbacc  = tlb_accesstag_w;
            end
        end
        c_after = 1'b0;
        if (c_got) begin
            @(negedge clk);
            c_after = resolve_done;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        resolve_request = 1'b0;
        satp_mode = 1'b0;
        satp_ppn = '0;
        resolve_virtual_address = '0;
        clr_tbl();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({resolve_ack, resolve_done, resolve_pagefault,
             resolve_accessfault, tlb_write, mem_read} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 000000",
                {resolve_ack, resolve_done, resolve_pagefault,
                 resolve_accessfault, tlb_write, mem_read});
        end
        n_cmp++;
        if ({resolve_physical_address, resolve_access_bits, tlb_virtual_address_w,
             tlb_phys_w, tlb_accesstag_w} !== 80'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h %h %h %h %h want all 0",
                resolve_physical_address, resolve_access_bits,
                tlb_virtual_address_w, tlb_phys_w, tlb_accesstag_w);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bare();
        int n0;
        n0 = n_reads;
        run_walk(1'b0, 20'h2_0000, 22'h0);
        n_cmp++;
        if (c_ack !== 1'b1) begin
            n_bad++; $display("FAIL bare_ack: got %b want 1", c_ack);
        end
        n_cmp++;
        if (c_got !== 1'b1 || c_lat != 1) begin
            n_bad++; $display("FAIL bare_latency: got %0d (done=%b) want 1", c_lat, c_got);
        end
        n_cmp++;
        if (c_phys !== 22'h2_0000 || c_acc !== 8'hFF) begin
            n_bad++; $display("FAIL bare_result: got %h/%h want 020000/ff", c_phys, c_acc);
        end
        n_cmp++;
        if ({c_pf, c_af, c_tlbw} !== 3'b000) begin
            n_bad++; $display("FAIL bare_flags: got %b want 000", {c_pf, c_af, c_tlbw});
        end
        n_cmp++;
        if (n_reads != n0) begin
            n_bad++; $display("FAIL bare_noread: got %0d reads want 0", n_reads - n0);
        end
        n_cmp++;
        if (c_after !== 1'b0) begin
            n_bad++; $display("FAIL bare_done_pulse: got %b want 0", c_after);
        end
    endtask

    task automatic test_two_level();
        int n0;
        clr_tbl();
        set_tbl(0, 34'h0_0010_0800, 32'h0000_8001, 2'b00);
        set_tbl(1, 34'h0_0002_0040, 32'h0400_00CF, 2'b00);
        n0 = n_reads;
        run_walk(1'b1, 20'h8_0010, 22'h100);
        n_cmp++;
        if (n_reads - n0 != 2 || addr_log[n0 % 4] !== 34'h0_0010_0800 ||
            addr_log[(n0 + 1) % 4] !== 34'h0_0002_0040) begin
            n_bad++;
            $display("FAIL two_addr: got %0d reads %h %h want 2 reads 0100800 0020040",
                n_reads - n0, addr_log[n0 % 4], addr_log[(n0 + 1) % 4]);
        end
        n_cmp++;
        if (c_got !== 1'b1 || c_phys !== 22'h1_0000 || c_acc !== 8'hCF) begin
            n_bad++;
            $display("FAIL two_result: got done=%b %h/%h want 1 010000/cf", c_got, c_phys, c_acc);
        end
        n_cmp++;
        if ({c_pf, c_af, c_tlbw} !== 3'b001) begin
            n_bad++; $display("FAIL two_flags: got %b want 001", {c_pf, c_af, c_tlbw});
        end
        n_cmp++;
        if (c_tlbva !== 20'h8_0010 || c_tlbphys !== 22'h1_0000 || c_tlbacc !== 8'hCF) begin
            n_bad++;
            $display("FAIL two_tlb: got %h %h %h want 80010 010000 cf", c_tlbva, c_tlbphys, c_tlbacc);
        end
    endtask

    task automatic test_megapage();
        clr_tbl();
        set_tbl(0, 34'h0_0010_0200, 32'h2000_00CF, 2'b00);
        run_walk(1'b1, 20'h2_0003, 22'h100);
        n_cmp++;
        if (c_got !== 1'b1 || c_lat != 3) begin
            n_bad++; $display("FAIL mega_latency: got %0d (done=%b) want 3", c_lat, c_got);
        end
        n_cmp++;
        if (c_phys !== 22'h8_0003 || c_acc !== 8'hCF || c_tlbw !== 1'b1 || c_pf !== 1'b0) begin
            n_bad++;
            $display("FAIL mega_result: got %h %h tlb=%b pf=%b want 080003 cf 1 0",
                c_phys, c_acc, c_tlbw, c_pf);
        end
        set_tbl(0, 34'h0_0010_0200, 32'h2000_04CF, 2'b00);
        run_walk(1'b1, 20'h2_0003, 22'h100);
        n_cmp++;
        if (c_got !== 1'b1 || {c_pf, c_af, c_tlbw} !== 3'b100) begin
            n_bad++;
            $display("FAIL mega_misaligned: got done=%b %b want 1 100", c_got, {c_pf, c_af, c_tlbw});
        end
        // leaf with A=0
        set_tbl(0, 34'h0_0010_0200, 32'h2000_008F, 2'b00);
        run_walk(1'b1, 20'h2_0003, 22'h100);
        n_cmp++;
`ifdef COREVX_PTW_ABIT_CHECK_EN
        if (c_got !== 1'b1 || {c_pf, c_tlbw} !== 2'b10) begin
            n_bad++; $display("FAIL abit: got done=%b %b want 1 10", c_got, {c_pf, c_tlbw});
        end
`else
        if (c_got !== 1'b1 || {c_pf, c_tlbw} !== 2'b01 || c_phys !== 22'h8_0003) begin
            n_bad++;
            $display("FAIL abit: got done=%b %b %h want 1 01 080003", c_got, {c_pf, c_tlbw}, c_phys);
        end
`endif
    endtask

    task automatic test_faults();
        clr_tbl();
        set_tbl(0, 34'h0_0010_0200, 32'h2000_00CF, 2'b10);
        run_walk(1'b1, 20'h2_0003, 22'h100);
        n_cmp++;
        if (c_got !== 1'b1 || {c_pf, c_af, c_tlbw} !== 3'b010) begin
            n_bad++; $display("FAIL fault_access: got done=%b %b want 1 010", c_got, {c_pf, c_af, c_tlbw});
        end
        set_tbl(0, 34'h0_0010_0200, 32'h0000_0000, 2'b00);
        run_walk(1'b1, 20'h2_0003, 22'h100);
        n_cmp++;
        if (c_got !== 1'b1 || {c_pf, c_af, c_tlbw} !== 3'b100) begin
            n_bad++; $display("FAIL fault_zero_pte: got done=%b %b want 1 100", c_got, {c_pf, c_af, c_tlbw});
        end
        set_tbl(0, 34'h0_0010_0200, 32'h2000_0005, 2'b00);
        run_walk(1'b1, 20'h2_0003, 22'h100);
        n_cmp++;
        if (c_got !== 1'b1 || {c_pf, c_af, c_tlbw} !== 3'b100) begin
            n_bad++; $display("FAIL fault_w_no_r: got done=%b %b want 1 100", c_got, {c_pf, c_af, c_tlbw});
        end
        clr_tbl();
        set_tbl(0, 34'h0_0010_0800, 32'h0000_8001, 2'b00);
        set_tbl(1, 34'h0_0002_0040, 32'h0000_0401, 2'b00);
        run_walk(1'b1, 20'h8_0010, 22'h100);
        n_cmp++;
        if (c_got !== 1'b1 || {c_pf, c_af, c_tlbw} !== 3'b100) begin
            n_bad++; $display("FAIL fault_l0_pointer: got done=%b %b want 1 100", c_got, {c_pf, c_af, c_tlbw});
        end
    endtask

    task automatic test_stall();
        int u0;
        clr_tbl();
        set_tbl(0, 34'h0_0010_0200, 32'h2000_00CF, 2'b00);
        m_wait = 3;
        u0 = unstable_cnt;
        run_walk(1'b1, 20'h2_0003, 22'h100);
        m_wait = 0;
        n_cmp++;
        if (c_got !== 1'b1 || c_lat != 6) begin
            n_bad++; $display("FAIL stall_latency: got %0d (done=%b) want 6", c_lat, c_got);
        end
        n_cmp++;
        if (unstable_cnt != u0) begin
            n_bad++; $display("FAIL stall_addr_stable: got %0d changes want 0", unstable_cnt - u0);
        end
        n_cmp++;
        if (c_phys !== 22'h8_0003 || c_tlbw !== 1'b1) begin
            n_bad++; $display("FAIL stall_result: got %h tlb=%b want 080003 1", c_phys, c_tlbw);
        end
    endtask

    task automatic test_ignore_busy();
        int acks;
        logic got;
        clr_tbl();
        set_tbl(0, 34'h0_0010_0200, 32'h2000_00CF, 2'b00);
        m_wait = 3;
        satp_mode = 1'b1;
        satp_ppn = 22'h100;
        resolve_virtual_address = 20'h2_0003;
        resolve_request = 1'b1;
        @(negedge clk);
        acks = 0;
        got = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resolve_ack) acks++;
        end
        resolve_request = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (resolve_ack) acks++;
            if (resolve_done) got = 1'b1;
        end
        m_wait = 0;
        @(negedge clk);
        n_cmp++;
        if (acks != 0 || got !== 1'b1) begin
            n_bad++; $display("FAIL busy_ignore: got %0d acks done=%b want 0 1", acks, got);
        end
    endtask

    task automatic test_reset_mid_walk();
        int bad_evt;
        clr_tbl();
        set_tbl(0, 34'h0_0010_0200, 32'h2000_00CF, 2'b00);
        m_lat = 4;
        satp_mode = 1'b1;
        satp_ppn = 22'h100;
        resolve_virtual_address = 20'h2_0003;
        resolve_request = 1'b1;
        @(negedge clk);
        resolve_request = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({mem_read, resolve_done, resolve_ack} !== 3'b000) begin
            n_bad++; $display("FAIL midrst_state: got %b want 000", {mem_read, resolve_done, resolve_ack});
        end
        bad_evt = 0;
        repeat (10) begin
            @(negedge clk);
            if (resolve_done || resolve_ack || mem_read || tlb_write) bad_evt++;
        end
        m_lat = 0;
        n_cmp++;
        if (bad_evt != 0) begin
            n_bad++; $display("FAIL midrst_late_data: got %0d events want 0", bad_evt);
        end
        run_walk(1'b1, 20'h2_0003, 22'h100);
        n_cmp++;
        if (c_got !== 1'b1 || c_lat != 3 || c_phys !== 22'h8_0003) begin
            n_bad++;
            $display("FAIL midrst_recover: got done=%b lat=%0d %h want 1 3 080003", c_got, c_lat, c_phys);
        end
    endtask

    initial begin
        test_reset();
        test_bare();
        test_two_level();
        test_megapage();
        test_faults();
        test_stall();
        test_ignore_busy();
        test_reset_mid_walk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
